// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: NOP encoding, default depth and
// the {PC, instruction} entry layout stored in the queue.
package fetch_queue_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam int          FQ_DEPTH  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // Bundle a fetched pair into one storage word.
  function automatic fq_entry_t make_entry(input logic [31:0] pc,
                                           input logic [31:0] instr);
    fq_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH-entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are never reset; validity lives in the
// parent's occupancy count.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fq_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output fq_entry_t       rdata
);

  fq_entry_t mem_q [DEPTH];

  // Write the addressed entry on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode. Holds the read/write
// pointers and the occupancy count, gives flush priority over push and pop,
// and masks the head outputs to PC 0 / NOP when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          fetch_stall,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic      full_s;
  logic      empty_s;
  logic      push_s;
  logic      pop_s;
  logic      we_s;
  fq_entry_t wdata_s;
  fq_entry_t head_s;

  // Full/empty come only from the registered count, so in_ready and
  // fetch_stall can only move on a clock edge (a same-cycle pop never
  // opens a slot for a same-cycle push).
  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == '0);
  assign push_s  = in_valid && !full_s;
  assign pop_s   = out_ready && !empty_s;

  // A flush discards any push in the same cycle, so nothing is written.
  assign we_s    = push_s && !flush;
  assign wdata_s = make_entry(in_pc, in_instr);

  // Next-state for pointers and count; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_q),
    .wdata (wdata_s),
    .raddr (rd_ptr_q),
    .rdata (head_s)
  );

  // Head outputs are a direct read at rd_ptr, masked when nothing is queued.
  always_comb begin
    out_valid = !empty_s;
    if (empty_s) begin
      out_pc    = 32'h0000_0000;
      out_instr = INSTR_NOP;
    end else begin
      out_pc    = head_s.pc;
      out_instr = head_s.instr;
    end
  end

  assign in_ready    = !full_s;
  assign fetch_stall = full_s;
  assign count       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based model of the FIFO behaviour.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          fetch_stall;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   count;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [63:0] mq[$];

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .fetch_stall (fetch_stall),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .flush       (flush),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a bounded queue updated on each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      int  sz;
      bit  acc;
      bit  pop;
      sz  = mq.size();
      acc = in_valid && (sz < DEPTH);
      pop = out_ready && (sz > 0);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({in_pc, in_instr});
    end
  end

  // Every-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("count",       64'(count),       64'(sz));
    chk("in_ready",    64'(in_ready),    64'(sz < DEPTH));
    chk("fetch_stall", 64'(fetch_stall), 64'(sz == DEPTH));
    chk("out_valid",   64'(out_valid),   64'(sz > 0));
    chk("out_pc",      64'(out_pc),      (sz > 0) ? 64'(mq[0][63:32]) : 64'h0);
    chk("out_instr",   64'(out_instr),   (sz > 0) ? 64'(mq[0][31:0])  : 64'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_pc = 32'h0; in_instr = 32'h0;
    idle();
    step(); step();
    chk("rst_out_valid",   64'(out_valid),   64'h0);
    chk("rst_out_pc",      64'(out_pc),      64'h0);
    chk("rst_out_instr",   64'(out_instr),   64'h0);
    chk("rst_in_ready",    64'(in_ready),    64'h1);
    chk("rst_fetch_stall", 64'(fetch_stall), 64'h0);
    chk("rst_count",       64'(count),       64'h0);
    rst = 1'b0;
    step();

    // First push: visible one cycle later.
    in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'h2008_0005;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 64'(out_valid), 64'h1);
    chk("t1_out_pc",    64'(out_pc),    64'h0);
    chk("t1_out_instr", 64'(out_instr), 64'h2008_0005);
    chk("t1_count",     64'(count),     64'h1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Fill to full, try a fifth push, then drain in order.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4); in_instr = 32'h1000 + 32'(i);
      step();
    end
    chk("fill_count",    64'(count),       64'h4);
    chk("fill_in_ready", 64'(in_ready),    64'h0);
    chk("fill_stall",    64'(fetch_stall), 64'h1);
    in_pc = 32'h10; step();
    in_valid = 1'b0;
    chk("fill_5th_count", 64'(count), 64'h4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(out_pc), 64'(i * 4));
      step();
    end
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'h0);

    // Full with simultaneous pop and push: push refused.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h20 + 32'(i * 4); in_instr = 32'h2000 + 32'(i);
      step();
    end
    in_pc = 32'h30; out_ready = 1'b1;
    step();
    idle();
    chk("fullpp_count",    64'(count),    64'h3);
    chk("fullpp_in_ready", 64'(in_ready), 64'h1);
    chk("fullpp_head",     64'(out_pc),   64'h24);

    // Flush with a same-cycle wrong-path push.
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h4040;
    step();
    idle();
    chk("flush_count",     64'(count),     64'h0);
    chk("flush_out_instr", 64'(out_instr), 64'h0);
    in_valid = 1'b1; in_pc = 32'h80; in_instr = 32'h8080;
    step();
    in_valid = 1'b0;
    chk("flush_head_pc", 64'(out_pc), 64'h80);
    chk("flush_count1",  64'(count),  64'h1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Streaming: one entry resident, push and pop every cycle across wraps.
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h5000;
    step();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_pc = 32'h104 + 32'(i * 4); in_instr = 32'h5001 + 32'(i);
      chk("stream_pc",    64'(out_pc), 64'h100 + 64'(i * 4));
      chk("stream_count", 64'(count),  64'h1);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;

    // Asynchronous reset between edges with two entries queued.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(i * 4); in_instr = 32'h6000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_arst_count", 64'(count), 64'h2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_count",     64'(count),     64'h0);
    chk("arst_in_ready",  64'(in_ready),  64'h1);
    step();
    rst = 1'b0;
    step();
    chk("post_arst_valid", 64'(out_valid), 64'h0);

    // Randomized traffic checked by the every-cycle model comparison.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < 50);
      flush     = ($urandom_range(99) < 5);
      in_pc     = $urandom();
      in_instr  = $urandom();
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
